// File: rtl/servo_move_sequencer.sv
// Timed motion scheduler: queues {direction, duration-ms} commands and plays them back
// in order to the servo PWM controller, finishing with a stop strobe.
module servo_move_sequencer #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int QDEPTH      = 4,
  parameter int DUR_W       = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd_dir,
  input  logic [DUR_W-1:0]          cmd_dur,
  output logic                      cmd_ready,
  input  logic                      abort,
  output logic [2:0]                direction,
  output logic                      use_servo,
  output logic                      busy,
  output logic                      cmd_done,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int CW         = $clog2(CYC_PER_MS);
  localparam int AW         = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;

  state_t             state, next_state;
  logic [2:0]         q_dir [QDEPTH];
  logic [DUR_W-1:0]   q_dur [QDEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [2:0]         cur_dir, dir_q, strobe_dir;
  logic [DUR_W-1:0]   cur_dur, ms_left;
  logic [CW-1:0]      cyc;
  logic               full, empty, push, pop, strobe, done;

  assign full      = (count == (AW+1)'(QDEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !reset && !abort && !full;
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      q_dir[wr_ptr] <= (cmd_dir == 3'b111) ? 3'b000 : cmd_dir;
      q_dur[wr_ptr] <= cmd_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // The LOAD cycle is occupancy cycle 0, so RUN ends when the last ms reaches its final cycle.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    strobe     = 1'b0;
    strobe_dir = 3'b000;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (cur_dur == '0) begin
          done = 1'b1;
          if (empty) next_state = STOP;
          else       pop = 1'b1;
        end else begin
          strobe     = 1'b1;
          strobe_dir = cur_dir;
          next_state = RUN;
        end
      end
      RUN: begin
        if (ms_left == DUR_W'(1) && cyc == CW'(CYC_PER_MS - 1)) begin
          done = 1'b1;
          if (empty) next_state = STOP;
          else begin
            pop        = 1'b1;
            next_state = LOAD;
          end
        end
      end
      STOP: begin
        strobe     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = STOP;
      pop        = 1'b0;
      strobe     = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dir_q   <= 3'b000;
      cur_dir <= 3'b000;
      cur_dur <= '0;
      ms_left <= '0;
      cyc     <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        cur_dir <= q_dir[rd_ptr];
        cur_dur <= q_dur[rd_ptr];
      end
      if (strobe) dir_q <= strobe_dir;
      if (state == LOAD) begin
        ms_left <= cur_dur;
        cyc     <= CW'(1);
      end else if (state == RUN) begin
        if (cyc == CW'(CYC_PER_MS - 1)) begin
          cyc     <= '0;
          ms_left <= ms_left - DUR_W'(1);
        end else begin
          cyc <= cyc + CW'(1);
        end
      end
    end
  end

  assign use_servo = reset || strobe;
  assign direction = reset ? 3'b000 : (strobe ? strobe_dir : dir_q);
  assign cmd_done  = !reset && done;
  assign busy      = !reset && (state == LOAD || state == RUN || !empty);
  assign q_count   = reset ? '0 : count;

endmodule
